alu_exec_unit: RTL and testbench

- Parametrised RV32I-style ALU decode-and-execute stage.
- Decodes opcode/funct3/funct7 bit 30 into a 4-bit ALU operation and executes it on XLEN-bit operands.
- Shifts run on an iterative multi-cycle shifter; a valid/ready handshake on both sides connects it between the decode stage and writeback/branch logic.
- Replaces the purely combinational ALU control path, adds SUB/SRA/SLT/SLTU, and fixes the I-type funct7 ambiguity.

---
 rtl/alu_exec_unit.sv | 199 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_exec_unit                                                  |
// | Purpose  : RV32I-style ALU decode-and-execute stage. Decodes opcode,      |
// |            funct3 and instruction bit 30 into a 4-bit ALU operation and   |
// |            executes it. Shifts use an iterative multi-cycle shifter that  |
// |            moves up to SHIFT_STEP bit positions per cycle.                |
// | Ports    : clk, rst (async, active-high)                                  |
// |            in_valid/in_ready   - request handshake from decode            |
// |            op/funct3/funct7_5  - instruction fields                       |
// |            src_a/src_b         - operands                                 |
// |            out_valid/out_ready - result handshake to writeback/branch     |
// |            result/zero/alu_ctrl/illegal - registered result and status    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      alu_ctrl,
    output logic            illegal
);

    localparam int c_SHW = $clog2(XLEN);
    localparam logic [c_SHW-1:0] c_STEP = c_SHW'(SHIFT_STEP);

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_ALUI = 7'b0010011;
    localparam logic [6:0] c_OP_ALU  = 7'b0110011;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;

    localparam logic [3:0] c_ADD  = 4'd0;
    localparam logic [3:0] c_SLL  = 4'd1;
    localparam logic [3:0] c_SLT  = 4'd2;
    localparam logic [3:0] c_SLTU = 4'd3;
    localparam logic [3:0] c_XOR  = 4'd4;
    localparam logic [3:0] c_SRL  = 4'd5;
    localparam logic [3:0] c_OR   = 4'd6;
    localparam logic [3:0] c_AND  = 4'd7;
    localparam logic [3:0] c_SUB  = 4'd8;
    localparam logic [3:0] c_SRA  = 4'd13;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       w_ctrl;
    logic             w_illegal;
    logic             w_is_shift;
    logic             w_multi;
    logic [c_SHW-1:0] w_shamt;
    logic [XLEN-1:0]  w_exec;
    logic             w_accept;

    logic [XLEN-1:0]  r_work;
    logic [c_SHW-1:0] r_rem;
    logic [c_SHW-1:0] w_step;
    logic [c_SHW-1:0] w_rem_nxt;
    logic [XLEN-1:0]  w_work_nxt;

    logic [XLEN-1:0]  r_result;
    logic             r_zero;
    logic [3:0]       r_ctrl;
    logic             r_illegal;

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign alu_ctrl  = r_ctrl;
    assign illegal   = r_illegal;

    assign w_accept   = in_ready && in_valid;
    assign w_shamt    = src_b[c_SHW-1:0];
    assign w_is_shift = !w_illegal && (w_ctrl == c_SLL || w_ctrl == c_SRL || w_ctrl == c_SRA);
    // Zero-distance shifts complete in one cycle like any other operation.
    assign w_multi    = w_is_shift && (w_shamt != '0);

    // Decode. Only register-register ALU ops use bit 30 to pick SUB; in the
    // immediate form that bit belongs to the immediate.
    always_comb begin
        w_ctrl    = c_ADD;
        w_illegal = 1'b0;
        case (op)
            c_OP_LW, c_OP_SW: w_ctrl = c_ADD;
            c_OP_BR:          w_ctrl = c_SUB;
            c_OP_ALU, c_OP_ALUI: begin
                case (funct3)
                    3'b000:  w_ctrl = (op == c_OP_ALU && funct7_5) ? c_SUB : c_ADD;
                    3'b001:  w_ctrl = c_SLL;
                    3'b010:  w_ctrl = c_SLT;
                    3'b011:  w_ctrl = c_SLTU;
                    3'b100:  w_ctrl = c_XOR;
                    3'b101:  w_ctrl = funct7_5 ? c_SRA : c_SRL;
                    3'b110:  w_ctrl = c_OR;
                    default: w_ctrl = c_AND;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Single-cycle execute. Shift ops only reach this path with shamt == 0,
    // where the result is src_a unchanged.
    always_comb begin
        w_exec = '0;
        case (w_ctrl)
            c_ADD:  w_exec = src_a + src_b;
            c_SUB:  w_exec = src_a - src_b;
            c_SLT:  w_exec = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            c_SLTU: w_exec = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            c_XOR:  w_exec = src_a ^ src_b;
            c_OR:   w_exec = src_a | src_b;
            c_AND:  w_exec = src_a & src_b;
            c_SLL, c_SRL, c_SRA: w_exec = src_a;
            default: w_exec = '0;
        endcase
        if (w_illegal) begin
            w_exec = '0;
        end
    end

    // Iterative shifter: the final step may be shorter than SHIFT_STEP.
    assign w_step    = (r_rem < c_STEP) ? r_rem : c_STEP;
    assign w_rem_nxt = r_rem - w_step;

    always_comb begin
        w_work_nxt = r_work >> w_step;
        case (r_ctrl)
            c_SLL:   w_work_nxt = r_work << w_step;
            c_SRA:   w_work_nxt = $unsigned($signed(r_work) >>> w_step);
            default: w_work_nxt = r_work >> w_step;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (in_valid) w_state_nxt = w_multi ? c_SHIFT : c_DONE;
            c_SHIFT: if (w_rem_nxt == '0) w_state_nxt = c_DONE;
            c_DONE:  if (out_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work    <= '0;
            r_rem     <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_ctrl    <= c_ADD;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_ctrl    <= w_ctrl;
            r_illegal <= w_illegal;
            if (w_multi) begin
                r_work <= src_a;
                r_rem  <= w_shamt;
            end else begin
                r_result <= w_exec;
                r_zero   <= (w_exec == '0);
            end
        end else if (r_state == c_SHIFT) begin
            r_work <= w_work_nxt;
            r_rem  <= w_rem_nxt;
            if (w_rem_nxt == '0) begin
                r_result <= w_work_nxt;
                r_zero   <= (w_work_nxt == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_exec_unit                                               |
// | Purpose  : Self-checking bench for alu_exec_unit. Instance 0 uses         |
// |            SHIFT_STEP=1, instance 1 uses SHIFT_STEP=4.                    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_exec_unit;

    localparam logic [6:0] c_LW = 7'b0000011, c_SW = 7'b0100011, c_ALUI = 7'b0010011;
    localparam logic [6:0] c_ALU = 7'b0110011, c_BR = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [2];
    logic        out_ready [2];
    logic [6:0]  op        [2];
    logic [2:0]  funct3    [2];
    logic        funct7_5  [2];
    logic [31:0] src_a     [2];
    logic [31:0] src_b     [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        zero      [2];
    logic        illegal   [2];
    logic [31:0] result    [2];
    logic [3:0]  alu_ctrl  [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) u_step1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op[0]), .funct3(funct3[0]), .funct7_5(funct7_5[0]),
        .src_a(src_a[0]), .src_b(src_b[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .result(result[0]), .zero(zero[0]),
        .alu_ctrl(alu_ctrl[0]), .illegal(illegal[0])
    );

    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) u_step4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op[1]), .funct3(funct3[1]), .funct7_5(funct7_5[1]),
        .src_a(src_a[1]), .src_b(src_b[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .result(result[1]), .zero(zero[1]),
        .alu_ctrl(alu_ctrl[1]), .illegal(illegal[1])
    );

    typedef struct {
        int          d;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  ctrl;
        logic        z;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model straight from the instruction-set rules.
    function automatic void model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                  input logic [31:0] a, input logic [31:0] b, input int step,
                                  output logic [31:0] res, output logic [3:0] ctrl,
                                  output logic ill, output int lat);
        int sh;
        sh   = int'(b % 32);
        ill  = !(o inside {c_LW, c_SW, c_ALUI, c_ALU, c_BR});
        ctrl = 4'd0;
        res  = 32'h0;
        lat  = 1;
        if (ill) return;
        if (o == c_BR) begin
            ctrl = 4'd8; res = a - b;
        end else if (o == c_LW || o == c_SW) begin
            ctrl = 4'd0; res = a + b;
        end else begin
            case (f3)
                3'd0: if (o == c_ALU && f7) begin ctrl = 4'd8; res = a - b; end
                      else begin ctrl = 4'd0; res = a + b; end
                3'd1: begin ctrl = 4'd1; res = a << sh; end
                3'd2: begin ctrl = 4'd2; res = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
                3'd3: begin ctrl = 4'd3; res = (a < b) ? 32'd1 : 32'd0; end
                3'd4: begin ctrl = 4'd4; res = a ^ b; end
                3'd5: if (f7) begin
                          ctrl = 4'd13;
                          res  = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
                      end else begin ctrl = 4'd5; res = a >> sh; end
                3'd6: begin ctrl = 4'd6; res = a | b; end
                default: begin ctrl = 4'd7; res = a & b; end
            endcase
            if (f3 == 3'd1 || f3 == 3'd5) lat = 1 + (sh + step - 1) / step;
        end
    endfunction

    task automatic issue(input int d, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op[d] = o; funct3[d] = f3; funct7_5[d] = f7; src_a[d] = a; src_b[d] = b;
        in_valid[d] = 1'b1;
        @(posedge clk);
        #1 in_valid[d] = 1'b0;
    endtask

    // Latency counts edges from the accept edge to the first edge at which
    // the consumer sees out_valid high.
    task automatic wait_valid(input int d, output int lat);
        lat = 1;
        while (!out_valid[d] && lat < 300) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic release_out(input string tag, input int d);
        @(negedge clk) out_ready[d] = 1'b1;
        @(posedge clk);
        #1 out_ready[d] = 1'b0;
        chk({tag, " in_ready after handshake"}, 32'(in_ready[d]), 32'd1);
    endtask

    task automatic run(input string tag, input vec_t v);
        int lat;
        issue(v.d, v.op, v.f3, v.f7, v.a, v.b);
        wait_valid(v.d, lat);
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        chk({tag, " result"},  result[v.d], v.res);
        chk({tag, " alu_ctrl"}, 32'(alu_ctrl[v.d]), 32'(v.ctrl));
        chk({tag, " zero"},    32'(zero[v.d]), 32'(v.z));
        chk({tag, " illegal"}, 32'(illegal[v.d]), 32'(v.ill));
        release_out(tag, v.d);
    endtask

    initial begin
        vec_t v;
        int   lat;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 0; out_ready[d] = 0; op[d] = 0; funct3[d] = 0;
            funct7_5[d] = 0; src_a[d] = 0; src_b[d] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset out_valid", 32'(out_valid[d]), 32'd0);
            chk("reset result",    result[d], 32'd0);
            chk("reset zero",      32'(zero[d]), 32'd0);
            chk("reset alu_ctrl",  32'(alu_ctrl[d]), 32'd0);
            chk("reset illegal",   32'(illegal[d]), 32'd0);
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", 32'(in_ready[0] & in_ready[1]), 32'd1);

        //              d  op      f3    f7 a             b             res           ctrl z  ill lat
        vecs.push_back('{0, c_ALU,  3'd0, 0, 32'd5,        32'd3,        32'd8,        4'd0, 0, 0, 1});
        vecs.push_back('{0, c_ALU,  3'd0, 1, 32'd5,        32'd3,        32'd2,        4'd8, 0, 0, 1});
        vecs.push_back('{0, c_ALUI, 3'd0, 1, 32'd5,        32'hFFFFFC00, 32'hFFFFFC05, 4'd0, 0, 0, 1});
        vecs.push_back('{0, c_ALU,  3'd5, 1, 32'h80000000, 32'd4,        32'hF8000000, 4'd13,0, 0, 5});
        vecs.push_back('{0, c_ALU,  3'd5, 0, 32'h80000000, 32'd4,        32'h08000000, 4'd5, 0, 0, 5});
        vecs.push_back('{1, c_ALU,  3'd1, 0, 32'd1,        32'd31,       32'h80000000, 4'd1, 0, 0, 9});
        vecs.push_back('{0, c_ALU,  3'd1, 0, 32'h1234,     32'h20,       32'h1234,     4'd1, 0, 0, 1});
        vecs.push_back('{0, c_BR,   3'd0, 0, 32'h1234,     32'h1234,     32'd0,        4'd8, 1, 0, 1});
        vecs.push_back('{0, c_ALU,  3'd2, 0, 32'd1,        32'd2,        32'd1,        4'd2, 0, 0, 1});
        vecs.push_back('{0, c_ALU,  3'd3, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'd3, 1, 0, 1});
        vecs.push_back('{0, 7'h7F,  3'd0, 0, 32'd5,        32'd3,        32'd0,        4'd0, 1, 1, 1});
        vecs.push_back('{1, c_SW,   3'd2, 0, 32'h100,      32'd4,        32'h104,      4'd0, 0, 0, 1});
        vecs.push_back('{1, c_ALU,  3'd5, 1, 32'h80000000, 32'd6,        32'hFE000000, 4'd13,0, 0, 3});
        vecs.push_back('{1, c_ALUI, 3'd5, 0, 32'hF0F0F0F0, 32'hFFFFFFE5, 32'h07878787, 4'd5, 0, 0, 3});
        foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i]);

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [6:0] ops [6];
            logic [31:0] r;
            ops = '{c_LW, c_SW, c_ALUI, c_ALU, c_BR, 7'h00};
            v.d  = i % 2;
            v.op = ops[$urandom_range(0, 5)];
            if (v.op == 7'h00) v.op = 7'($urandom);
            v.f3 = 3'($urandom);
            v.f7 = 1'($urandom);
            v.a  = $urandom;
            v.b  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            model(v.op, v.f3, v.f7, v.a, v.b, (v.d == 0) ? 1 : 4, r, v.ctrl, v.ill, v.lat);
            v.res = r;
            v.z   = (r == 32'h0);
            run($sformatf("rand%0d", i), v);
        end

        // Backpressure: result held, extra requests ignored.
        issue(0, c_ALU, 3'd0, 0, 32'd7, 32'd9);
        wait_valid(0, lat);
        chk("bp latency", 32'(lat), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid[0] = 1'b1; src_a[0] = $urandom; funct3[0] = 3'($urandom);
            @(posedge clk);
            #1;
            chk("bp result",    result[0], 32'd16);
            chk("bp out_valid", 32'(out_valid[0]), 32'd1);
            chk("bp in_ready",  32'(in_ready[0]), 32'd0);
            chk("bp alu_ctrl",  32'(alu_ctrl[0]), 32'd0);
        end
        @(negedge clk) in_valid[0] = 1'b0;
        release_out("bp", 0);
        chk("bp out_valid after handshake", 32'(out_valid[0]), 32'd0);

        // Reset in the middle of a long shift.
        issue(0, c_ALU, 3'd5, 0, 32'hFFFF0000, 32'd20);
        repeat (4) @(posedge clk);
        #1 chk("mid-shift out_valid", 32'(out_valid[0]), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst mid-shift out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst mid-shift result",    result[0], 32'd0);
        chk("rst mid-shift alu_ctrl",  32'(alu_ctrl[0]), 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (30) @(posedge clk);
        #1 chk("no output from discarded shift", 32'(out_valid[0]), 32'd0);
        chk("in_ready after mid-shift reset", 32'(in_ready[0]), 32'd1);
        v = '{0, c_ALU, 3'd0, 0, 32'd100, 32'd23, 32'd123, 4'd0, 0, 0, 1};
        run("post-reset add", v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
